// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a
// one-entry holding register with valid/ready output and error pulses.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 64
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Uart_rx,
   output logic [7:0] Rx_data,
   output logic       Rx_valid,
   input  logic       Rx_ready,
   output logic       Frame_err,
   output logic       Overrun,
   output logic [2:0] state_dbg
);

   // Handshake: a byte transfers in every cycle where Rx_valid && Rx_ready;
   // Rx_data is held stable while Rx_valid is high and Rx_ready is low.

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       idx, idx_nx;
   logic [7:0]       shift, shift_nx;
   logic             rx_meta, rx_s;
   logic             good_stop, bad_stop;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= Uart_rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         shift <= shift_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      idx_nx    = idx;
      shift_nx  = shift;
      good_stop = 1'b0;
      bad_stop  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            idx_nx = '0;
            if (!rx_s) state_nx = START;
         end
         START: begin
            // A start bit must still be low at its midpoint, otherwise it was a glitch.
            if (cnt == HALF_LAST) begin
               cnt_nx   = '0;
               idx_nx   = '0;
               state_nx = rx_s ? IDLE : DATA;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nx        = '0;
               shift_nx[idx] = rx_s;
               idx_nx        = idx + 3'd1;
               if (idx == 3'd7) state_nx = STOP;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nx = '0;
               if (rx_s) begin
                  good_stop = 1'b1;
                  state_nx  = IDLE;
               end else begin
                  bad_stop = 1'b1;
                  state_nx = WAIT_HIGH;
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         WAIT_HIGH: begin
            // Hold off through a break so it yields a single Frame_err.
            cnt_nx = '0;
            if (rx_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Rx_data   <= 8'h00;
         Rx_valid  <= 1'b0;
         Frame_err <= 1'b0;
         Overrun   <= 1'b0;
      end else begin
         Frame_err <= bad_stop;
         Overrun   <= good_stop && Rx_valid && !Rx_ready;
         if (good_stop && (!Rx_valid || Rx_ready)) begin
            Rx_data  <= shift;
            Rx_valid <= 1'b1;
         end else if (Rx_valid && Rx_ready) begin
            Rx_valid <= 1'b0;
         end
      end
   end

   assign state_dbg = state;

endmodule
